// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared FSM state encoding and WIDTH bounds for the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int c_width_min = 1;
   localparam int c_width_max = 64;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_if
// Purpose  : Operand-request and result handshakes of the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output start_valid, a, b, cin, result_ready,
      input  start_ready, result_valid, sum, cout, busy
   );

   modport slave (
      input  start_valid, a, b, cin, result_ready,
      output start_ready, result_valid, sum, cout, busy
   );
endinterface
`default_nettype wire

// File: rtl/serial_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_full_adder
// Purpose  : Combinational 1-bit full adder shared across all operand bits.
// Revision : 1.0 - initial release
// ============================================================================
module serial_full_adder (
   input  wire logic a,
   input  wire logic b,
   input  wire logic cin,
   output logic      out,
   output logic      cout
);
   assign out  = a ^ b ^ cin;
   assign cout = (a & b) | (b & cin) | (a & cin);
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : LSB-first bit-serial adder controller around one full adder.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic          CLK,
   input  wire logic          RESET,
   serial_adder_ctrl_if.slave bus
);
   localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

   if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH out of range");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_start_ready;
   logic             r_result_valid;
   logic             r_busy;

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_sum_next;

   serial_full_adder u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .out  (w_fa_sum),
      .cout (w_fa_cout)
   );

   // New sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_fa_sum;
   end else begin : g_sum_wn
      assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state        <= IDLE;
         r_a_sh         <= '0;
         r_b_sh         <= '0;
         r_sum_sh       <= '0;
         r_carry        <= 1'b0;
         r_count        <= '0;
         r_sum          <= '0;
         r_cout         <= 1'b0;
         r_start_ready  <= 1'b1;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start_valid) begin
                  r_a_sh        <= bus.a;
                  r_b_sh        <= bus.b;
                  r_carry       <= bus.cin;
                  r_count       <= '0;
                  r_state       <= RUN;
                  r_start_ready <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end
            RUN: begin
               r_sum_sh <= w_sum_next;
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_carry  <= w_fa_cout;
               r_count  <= r_count + CW'(1);
               if (r_count == c_last) begin
                  // Capture the result here so sum/cout hold through DONE and IDLE.
                  r_sum          <= w_sum_next;
                  r_cout         <= w_fa_cout;
                  r_state        <= DONE;
                  r_result_valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  r_state        <= IDLE;
                  r_result_valid <= 1'b0;
                  r_busy         <= 1'b0;
                  r_start_ready  <= 1'b1;
               end
            end
            default: begin
               r_state        <= IDLE;
               r_result_valid <= 1'b0;
               r_busy         <= 1'b0;
               r_start_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.start_ready  = r_start_ready;
   assign bus.result_valid = r_result_valid;
   assign bus.busy         = r_busy;
   assign bus.sum          = r_sum;
   assign bus.cout         = r_cout;
endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that time-shares one single-bit full adder across a WIDTH-bit operand pair. It accepts an operand pair over a valid/ready handshake and shifts the operands LSB-first through the full adder, one bit per cycle. A carry register closes the loop between cycles. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between a requester and the shared 1-bit adder datapath, trading area for latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..64.
CW, $clog2(WIDTH) with a minimum of 1, bit-counter width; derived, not overridable.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
start_valid  input  1  requester presents an operand pair.
start_ready  output  1  controller can accept an operand pair.
a  input  WIDTH  operand A; sampled only on the accept edge.
b  input  WIDTH  operand B; sampled only on the accept edge.
cin  input  1  carry-in; sampled only on the accept edge.
result_valid  output  1  sum and cout are valid.
result_ready  input  1  consumer takes the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Binary encoding is taken from the shared package.
- Reset (RESET=1 at an edge, from any state):
  - State goes to IDLE.
  - Shift registers, carry register and counter clear to 0.
  - Outputs: start_ready=1, result_valid=0, sum=0, cout=0, busy=0.
  - RESET has priority over all handshakes. A reset mid-RUN or mid-DONE aborts the operation silently.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: a_sh<=a, b_sh<=b, carry<=cin, count<=0, sum_sh is left unchanged, state goes to RUN.
  - Otherwise the state holds.
- RUN (start_ready=0, busy=1):
  - Each edge feeds the full adder with a_sh[0], b_sh[0] and carry.
  - Updates per edge: sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}, a_sh and b_sh shift right by one, carry<=fa_cout, count<=count+1.
  - The edge on which count==WIDTH-1 moves the state to DONE. With WIDTH=1, that is the first RUN edge.
  - start_valid is ignored. a, b and cin are not sampled.
- DONE (result_valid=1, busy=1, start_ready=0):
  - sum=sum_sh and cout=carry, held stable until the handshake.
  - On an edge with result_ready=1, the state goes to IDLE. sum and cout keep their last value; result_valid drops.
  - There is no DONE-to-RUN bypass. A new operation is accepted no earlier than the edge after the result handshake.
- Latency:
  - result_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum initiation interval is WIDTH+2 cycles.
- Outputs:
  - start_ready, result_valid and busy are decoded directly from the state register (Moore).
  - No input-to-output combinational paths.
- Arithmetic: sum and cout together equal the (WIDTH+1)-bit value a+b+cin, with cout as the MSB. Wrap-around is natural modulo 2^WIDTH.
- Counter:
  - CW bits wide.
  - It never exceeds WIDTH-1 while in RUN.
  - Its value in IDLE and DONE is don't-care, except after reset, when it is 0.

Decomposition:
- Shared package serial_adder_pkg contains:
  - the state typedef with encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH bound constants (1, 64).
- One sub-module: serial_full_adder, a purely combinational 1-bit full adder.
  - Inputs a, b, cin; outputs out (sum) and cout.
  - out = a^b^cin; cout = (a&b)|(b&cin)|(a&cin).
  - Instantiated once inside serial_adder_ctrl.
- Everything else (FSM, shift registers, counter) lives in serial_adder_ctrl.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, cin=0, result_ready=1 -> result_valid rises 8 edges after accept; sum=0x96, cout=0; start_ready reasserts the cycle after the handshake.
- WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry ripple and wrap).
- Backpressure: result_ready held at 0 for 5 cycles after result_valid -> sum/cout/result_valid stable throughout; start_valid=1 with new operands during that window is not accepted (start_ready=0); accepted on the cycle after the handshake.
- Operand change in RUN: change a/b/cin every cycle after accept of a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0, unaffected.
- Reset mid-RUN: assert RESET for 1 cycle at bit 4 of a=0xAA+0x55 -> next cycle IDLE, start_ready=1, result_valid=0, sum=0, cout=0, busy=0; a fresh 0x01+0x01 then yields sum=0x02.
- WIDTH=1: a=1, b=1, cin=1 -> result_valid 1 edge after accept; sum=1, cout=1. Back-to-back requests achieve an initiation interval of 3 cycles.
